btn_event_gen: RTL and testbench



---
 rtl/btn_event_gen_pkg.sv | 18 +
 rtl/btn_event_gen.sv | 100 ++++++++++
 tb/tb_btn_event_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/btn_event_gen_pkg.sv
// Shared state encodings and repeat-count sizing for the button event generator.
package btn_event_gen_pkg;

    localparam int REP_CNT_W = 8;
    localparam logic [REP_CNT_W-1:0] REP_CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2,
        ILLEGAL = 2'd3
    } btnState_t;

    function automatic logic [REP_CNT_W-1:0] satInc(input logic [REP_CNT_W-1:0] v);
        return (v == REP_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/btn_event_gen.sv
// Turns a debounced button level into press/release/long/repeat one-cycle pulses.
// Moore FSM sharing one cycle counter between the long-press and repeat timers.
module btn_event_gen
    import btn_event_gen_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iBtn,
    output logic                 oPress,
    output logic                 oRelease,
    output logic                 oLong,
    output logic                 oRepeat,
    output logic                 oHeld,
    output logic [REP_CNT_W-1:0] oRepCnt,
    output logic [1:0]           oState
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    btnState_t        state;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    assign oState = state;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            armed    <= 1'b0;
            cnt      <= '0;
            oPress   <= 1'b0;
            oRelease <= 1'b0;
            oLong    <= 1'b0;
            oRepeat  <= 1'b0;
            oHeld    <= 1'b0;
            oRepCnt  <= '0;
        end else begin
            oPress   <= 1'b0;
            oRelease <= 1'b0;
            oLong    <= 1'b0;
            oRepeat  <= 1'b0;
            // Arming needs a sampled low so a button held through reset is ignored.
            armed    <= armed | ~iBtn;

            case (state)
                IDLE: begin
                    if (armed && iBtn) begin
                        state   <= PRESSED;
                        oPress  <= 1'b1;
                        oHeld   <= 1'b1;
                        cnt     <= '0;
                        oRepCnt <= '0;
                    end
                end

                PRESSED: begin
                    if (!iBtn) begin
                        state    <= IDLE;
                        oRelease <= 1'b1;
                        oHeld    <= 1'b0;
                        cnt      <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state <= LONG;
                        oLong <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                LONG: begin
                    if (!iBtn) begin
                        state    <= IDLE;
                        oRelease <= 1'b1;
                        oHeld    <= 1'b0;
                        cnt      <= '0;
                    end else if (cnt == REP_LAST) begin
                        oRepeat <= 1'b1;
                        oRepCnt <= satInc(oRepCnt);
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    oHeld <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_gen.sv
// Randomized and directed check of btn_event_gen against an elapsed-time hold model.
module tb_btn_event_gen;

    localparam int LC = 8;
    localparam int RC = 4;
    localparam int CW = 4;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iBtn = 1'b0;
    logic       oPress, oRelease, oLong, oRepeat, oHeld;
    logic [7:0] oRepCnt;
    logic [1:0] oState;

    int errors = 0;
    int checks = 0;

    // Reference model: hold tracked as elapsed cycles since the press edge.
    bit mArmed, mHeld;
    int mT, mRep;
    bit ePress, eRel, eLong, eRep;

    btn_event_gen #(.LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .CNT_W(CW)) dut (
        .iClk(iClk), .iRst(iRst), .iBtn(iBtn),
        .oPress(oPress), .oRelease(oRelease), .oLong(oLong), .oRepeat(oRepeat),
        .oHeld(oHeld), .oRepCnt(oRepCnt), .oState(oState)
    );

    always #5 iClk = ~iClk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic modelReset();
        mArmed = 0; mHeld = 0; mT = 0; mRep = 0;
        ePress = 0; eRel = 0; eLong = 0; eRep = 0;
    endtask

    task automatic modelEdge(input bit b);
        ePress = 0; eRel = 0; eLong = 0; eRep = 0;
        if (!mHeld) begin
            if (mArmed && b) begin
                ePress = 1; mHeld = 1; mT = 0; mRep = 0;
            end
        end else if (!b) begin
            eRel = 1; mHeld = 0;
        end else begin
            mT++;
            if (mT == LC) eLong = 1;
            else if (mT > LC && (mT - LC) % RC == 0) begin
                eRep = 1;
                if (mRep < 255) mRep++;
            end
        end
        if (!b) mArmed = 1;
    endtask

    function automatic logic [14:0] expVec();
        logic [1:0] st;
        st = !mHeld ? 2'd0 : (mT >= LC ? 2'd2 : 2'd1);
        return {ePress, eRel, eLong, eRep, mHeld, 8'(mRep), st};
    endfunction

    function automatic logic [14:0] obsVec();
        return {oPress, oRelease, oLong, oRepeat, oHeld, oRepCnt, oState};
    endfunction

    task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit b, input string tag);
        @(negedge iClk);
        iBtn = b;
        @(posedge iClk);
        modelEdge(b);
        #1 check(tag, obsVec(), expVec());
    endtask

    task automatic run(input bit b, input int n, input string tag);
        for (int i = 0; i < n; i++) step(b, tag);
    endtask

    int pressCnt;

    initial begin
        modelReset();
        iRst = 1'b1;
        iBtn = 1'b0;
        @(posedge iClk);
        #1 check("reset_state", obsVec(), 15'd0);
        @(negedge iClk);
        iRst = 1'b0;

        // 1: short press, no long
        run(0, 3, "t1_idle");
        run(1, 5, "t1_hold");
        step(0, "t1_release");
        check("t1_repcnt", {7'd0, oRepCnt}, 15'd0);
        run(0, 2, "t1_gap");

        // 2: long hold with five repeats
        run(1, 30, "t2_hold");
        check("t2_repcnt_before_rel", {7'd0, oRepCnt}, 15'd5);
        step(0, "t2_release");
        check("t2_repcnt_after_rel", {7'd0, oRepCnt}, 15'd5);
        run(0, 2, "t2_gap");

        // 3: release exactly on the long threshold
        run(1, 8, "t3_hold");
        step(0, "t3_release_on_long");
        check("t3_state", {13'd0, oState}, 15'd0);
        run(0, 1, "t3_gap");

        // Release on a repeat threshold, then press with the minimum gap
        run(1, 12, "rep_thresh_hold");
        step(0, "rep_thresh_release");
        step(1, "min_gap_press");
        step(0, "min_gap_release");

        // 4: held through reset gives no phantom press
        @(negedge iClk);
        iRst = 1'b1;
        iBtn = 1'b1;
        modelReset();
        @(posedge iClk);
        #1 check("t4_in_reset", obsVec(), expVec());
        @(negedge iClk);
        iRst = 1'b0;
        run(1, 10, "t4_held_no_arm");
        step(0, "t4_arm");
        step(1, "t4_press");
        run(1, 3, "t4_hold");
        step(0, "t4_release");

        // 5: asynchronous reset mid-LONG
        run(1, 12, "t5_to_long");
        check("t5_in_long", {13'd0, oState}, 15'd2);
        @(negedge iClk);
        #2 iRst = 1'b1;
        iBtn = 1'b0;
        #1 check("t5_async_clear", obsVec(), 15'd0);
        modelReset();
        @(posedge iClk);
        #1 check("t5_no_release", obsVec(), expVec());
        @(negedge iClk);
        iRst = 1'b0;
        run(0, 3, "t5_idle");
        run(1, 5, "t5_hold");
        step(0, "t5_release");

        // 6: repeat-count saturation
        run(1, 8 + 4 * 260 + 3, "t6_hold");
        check("t6_sat", {7'd0, oRepCnt}, 15'd255);
        step(0, "t6_release");

        // Random press/release patterns
        pressCnt = 0;
        for (int k = 0; k < 40; k++) begin
            run(0, $urandom_range(1, 4), "rnd_low");
            run(1, $urandom_range(1, 40), "rnd_high");
            pressCnt++;
        end
        step(0, "rnd_final_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
